pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the microprocessor fetch stage. It generalises the basic PC with configurable address width, reset vector, step and alignment. It adds absolute jumps, PC-relative branches, call/return through an internal return-address stack (RAS), a stall input, and alignment and stack error reporting. It feeds instruction memory and the branch/link datapath.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the fetch command encodings and the width helper for the
// return-address stack level counter.
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD    = 3'd0,
        CMD_INC     = 3'd1,
        CMD_JUMP    = 3'd2,
        CMD_BRANCH  = 3'd3,
        CMD_CALL    = 3'd4,
        CMD_RET     = 3'd5,
        CMD_RESTART = 3'd6,
        CMD_RSVD    = 3'd7
    } pc_cmd_t;

    // Level counter must represent 0..depth inclusive, hence the extra bit.
    function automatic int ras_lw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int RAS_LW = ras_lw(4);

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, pop     - push din / pop the top entry (never both in one cycle)
//   clear         - empty the stack
//   din, dout     - entry to push / current top entry (combinational)
//   level         - number of valid entries
//   full, empty   - level == RAS_DEPTH / level == 0
// A push while full overwrites the oldest entry; level saturates.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          clear,
    input  logic [XLEN-1:0]               din,
    output logic [XLEN-1:0]               dout,
    output logic [ras_lw(RAS_DEPTH)-1:0]  level,
    output logic                          full,
    output logic                          empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int LW = ras_lw(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   top_idx;
    logic [LW-1:0]   lvl_q;

    // Depth is a power of two, so the pointer wraps naturally; the oldest
    // entry is always the next one overwritten once the stack is full.
    assign top_idx = wr_ptr - PW'(1);
    assign dout    = mem[top_idx];
    assign level   = lvl_q;
    assign full    = (lvl_q == LW'(RAS_DEPTH));
    assign empty   = (lvl_q == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            lvl_q  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!full)
                lvl_q <= lvl_q + LW'(1);
        end else if (pop && !empty) begin
            wr_ptr <= top_idx;
            lvl_q  <= lvl_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   stall           - hold all state and ignore cmd
//   cmd             - fetch command (pc_cmd_t encodings)
//   target, offset  - absolute jump/call address, signed branch displacement
//   pc_o, pc_inc    - current PC, PC + STEP
//   ras_level/empty/full - return-address stack occupancy
//   err_misalign/ovf/unf - one-cycle registered error pulses
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              STEP       = 4,
    parameter int              ALIGN_BITS = 2,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [2:0]                    cmd,
    input  logic [XLEN-1:0]               target,
    input  logic [XLEN-1:0]               offset,
    output logic [XLEN-1:0]               pc_o,
    output logic [XLEN-1:0]               pc_inc,
    output logic [ras_lw(RAS_DEPTH)-1:0]  ras_level,
    output logic                          ras_empty,
    output logic                          ras_full,
    output logic                          err_misalign,
    output logic                          err_ovf,
    output logic                          err_unf
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

    pc_cmd_t         cmd_e;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] cand;
    logic [XLEN-1:0] ras_dout;
    logic            cand_bad;
    logic            push, pop, clear;
    logic            mis_nxt, ovf_nxt, unf_nxt;

    assign cmd_e    = pc_cmd_t'(cmd);
    assign pc_o     = pc_q;
    assign pc_inc   = pc_q + XLEN'(STEP);
    assign cand_bad = |(cand & ALIGN_MASK);

    always_comb begin
        pc_nxt  = pc_q;
        cand    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        mis_nxt = 1'b0;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (!stall) begin
            case (cmd_e)
                CMD_INC: pc_nxt = pc_inc;
                CMD_JUMP, CMD_BRANCH: begin
                    cand = (cmd_e == CMD_JUMP) ? target : pc_q + offset;
                    if (cand_bad) mis_nxt = 1'b1;
                    else          pc_nxt  = cand;
                end
                CMD_CALL: begin
                    cand = target;
                    if (cand_bad) begin
                        mis_nxt = 1'b1;
                    end else begin
                        pc_nxt  = cand;
                        push    = 1'b1;
                        ovf_nxt = ras_full;
                    end
                end
                CMD_RET: begin
                    // Underflow is reported before alignment: an empty stack
                    // has no meaningful return address to check.
                    cand = ras_dout;
                    if (ras_empty) begin
                        unf_nxt = 1'b1;
                    end else if (cand_bad) begin
                        mis_nxt = 1'b1;
                    end else begin
                        pc_nxt = cand;
                        pop    = 1'b1;
                    end
                end
                CMD_RESTART: begin
                    pc_nxt = RESET_VEC;
                    clear  = 1'b1;
                end
                default: pc_nxt = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            err_misalign <= 1'b0;
            err_ovf      <= 1'b0;
            err_unf      <= 1'b0;
        end else begin
            pc_q         <= pc_nxt;
            err_misalign <= mis_nxt;
            err_ovf      <= ovf_nxt;
            err_unf      <= unf_nxt;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (pc_inc),
        .dout  (ras_dout),
        .level (ras_level),
        .full  (ras_full),
        .empty (ras_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [2:0]  cmd;
    logic [31:0] target, offset;
    logic [31:0] pc_o, pc_inc;
    logic [2:0]  ras_level;
    logic        ras_empty, ras_full, err_misalign, err_ovf, err_unf;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .cmd(cmd),
        .target(target), .offset(offset),
        .pc_o(pc_o), .pc_inc(pc_inc), .ras_level(ras_level),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .err_misalign(err_misalign), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  cmd;
        logic [31:0] target;
        logic [31:0] offset;
        logic [31:0] pc;
        logic [2:0]  lvl;
        logic [2:0]  err;   // {misalign, ovf, unf}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [2:0] c,
                       input logic [31:0] t, input logic [31:0] o,
                       input logic [31:0] p, input logic [2:0] l,
                       input logic [2:0] e);
        vec_t v;
        v.rst = r; v.stall = s; v.cmd = c; v.target = t; v.offset = o;
        v.pc = p; v.lvl = l; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic [31:0] p,
                               input logic [2:0] l, input logic [2:0] e);
        chk("pc_o", idx, pc_o, p);
        chk("pc_inc", idx, pc_inc, p + 32'd4);
        chk("ras_level", idx, 32'(ras_level), 32'(l));
        chk("ras_empty", idx, 32'(ras_empty), 32'(l == 3'd0));
        chk("ras_full", idx, 32'(ras_full), 32'(l == 3'd4));
        chk("err", idx, {29'd0, err_misalign, err_ovf, err_unf}, {29'd0, e});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; cmd = 3'd0; target = '0; offset = '0;

        //    rst  stl cmd      target        offset        pc            lvl err
        add(1'b1,1'b1,3'd2, 32'h40,       32'h0,        32'h0,        3'd0,3'b000); // 0 reset beats stall/jump
        add(1'b0,1'b0,3'd1, 32'h0,        32'h0,        32'h4,        3'd0,3'b000);
        add(1'b0,1'b0,3'd1, 32'h0,        32'h0,        32'h8,        3'd0,3'b000);
        add(1'b0,1'b0,3'd1, 32'h0,        32'h0,        32'hC,        3'd0,3'b000);
        add(1'b0,1'b0,3'd2, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 3'd0,3'b000);
        add(1'b0,1'b0,3'd1, 32'h0,        32'h0,        32'h0,        3'd0,3'b000); // 5 wrap
        add(1'b0,1'b0,3'd2, 32'h100,      32'h0,        32'h100,      3'd0,3'b000);
        add(1'b0,1'b0,3'd3, 32'h0,        32'hFFFFFFF0, 32'hF0,       3'd0,3'b000); // backward branch
        add(1'b0,1'b0,3'd3, 32'h0,        32'h6,        32'hF0,       3'd0,3'b100); // misaligned branch
        add(1'b0,1'b0,3'd0, 32'h0,        32'h0,        32'hF0,       3'd0,3'b000); // pulse ends
        add(1'b0,1'b0,3'd2, 32'h10,       32'h0,        32'h10,       3'd0,3'b000); // 10
        add(1'b0,1'b0,3'd4, 32'h20,       32'h0,        32'h20,       3'd1,3'b000);
        add(1'b0,1'b0,3'd4, 32'h30,       32'h0,        32'h30,       3'd2,3'b000);
        add(1'b0,1'b0,3'd4, 32'h40,       32'h0,        32'h40,       3'd3,3'b000);
        add(1'b0,1'b0,3'd4, 32'h50,       32'h0,        32'h50,       3'd4,3'b000);
        add(1'b0,1'b0,3'd4, 32'h60,       32'h0,        32'h60,       3'd4,3'b010); // 15 overflow
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h54,       3'd3,3'b000);
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h44,       3'd2,3'b000);
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h34,       3'd1,3'b000);
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h24,       3'd0,3'b000);
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h24,       3'd0,3'b001); // 20 underflow
        add(1'b0,1'b0,3'd0, 32'h0,        32'h0,        32'h24,       3'd0,3'b000);
        add(1'b0,1'b0,3'd4, 32'h80,       32'h0,        32'h80,       3'd1,3'b000);
        add(1'b0,1'b1,3'd4, 32'h90,       32'h0,        32'h80,       3'd1,3'b000); // stalled call
        add(1'b0,1'b1,3'd5, 32'h0,        32'h0,        32'h80,       3'd1,3'b000); // stalled ret
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h28,       3'd0,3'b000); // 25
        add(1'b0,1'b0,3'd2, 32'h102,      32'h0,        32'h28,       3'd0,3'b100); // misaligned jump
        add(1'b0,1'b0,3'd4, 32'h101,      32'h0,        32'h28,       3'd0,3'b100); // misaligned call, no push
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h28,       3'd0,3'b001);
        add(1'b0,1'b0,3'd2, 32'h200,      32'h0,        32'h200,      3'd0,3'b000);
        add(1'b0,1'b0,3'd4, 32'h300,      32'h0,        32'h300,      3'd1,3'b000); // 30
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h204,      3'd0,3'b000); // call then ret
        add(1'b0,1'b0,3'd4, 32'h200,      32'h0,        32'h200,      3'd1,3'b000);
        add(1'b0,1'b0,3'd4, 32'h200,      32'h0,        32'h200,      3'd2,3'b000);
        add(1'b0,1'b0,3'd4, 32'h200,      32'h0,        32'h200,      3'd3,3'b000);
        add(1'b0,1'b0,3'd6, 32'h0,        32'h0,        32'h0,        3'd0,3'b000); // 35 restart
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h0,        3'd0,3'b001);
        add(1'b0,1'b0,3'd7, 32'h80,       32'h8,        32'h0,        3'd0,3'b000); // reserved
        add(1'b0,1'b0,3'd4, 32'h40,       32'h0,        32'h40,       3'd1,3'b000);
        add(1'b1,1'b0,3'd4, 32'h80,       32'h0,        32'h0,        3'd0,3'b000); // reset mid-sequence
        add(1'b0,1'b0,3'd5, 32'h0,        32'h0,        32'h0,        3'd0,3'b001); // 40
        add(1'b0,1'b0,3'd3, 32'h0,        32'h10,       32'h10,       3'd0,3'b000);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; cmd = vecs[i].cmd;
            target = vecs[i].target; offset = vecs[i].offset;
            @(posedge clk);
            #1;
            check_state(i, vecs[i].pc, vecs[i].lvl, vecs[i].err);
        end

        // Long stall with INC pending: PC must not move until stall drops.
        @(negedge clk);
        rst = 1'b0; stall = 1'b1; cmd = 3'd1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_state(100 + k, 32'h10, 3'd0, 3'b000);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_state(103, 32'h14, 3'd0, 3'b000);

        // Overflow pulse lasts one cycle even with a following call.
        @(negedge clk);
        cmd = 3'd6;
        @(posedge clk);
        #1;
        check_state(104, 32'h0, 3'd0, 3'b000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmd = 3'd4; target = 32'h100 * (k + 1);
            @(posedge clk);
            #1;
            check_state(105 + k, 32'h100 * (k + 1), (k < 4) ? 3'(k + 1) : 3'd4,
                        (k == 4) ? 3'b010 : 3'b000);
        end
        @(negedge clk);
        cmd = 3'd5;
        @(posedge clk);
        #1;
        check_state(110, 32'h404, 3'd3, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
